// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types and constants for the RMII receive framer.
//   state_t        framer state machine encoding (also exported on dbg_state)
//   PREAMBLE_DIBIT preamble dibit value on the wire
//   SFD_DIBIT      final dibit of the start-of-frame delimiter
//   CRC_*          reflected CRC-32 constants used when ETH_RX_CRC_CHECK_EN is defined
//   BCAST_ADDR     Ethernet broadcast destination
//   crc32_dibit()  advances a reflected CRC-32 register by one RMII dibit
package eth_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    PAYLOAD  = 3'd3,
    DISCARD  = 3'd4,
    FLUSH    = 3'd5
  } state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_POLY_R     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
  localparam logic [47:0] BCAST_ADDR     = 48'hFFFF_FFFF_FFFF;

  // Bit 0 of the dibit is the earlier bit on the wire, so it is folded in first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] r;
    r = crc;
    for (int i = 0; i < 2; i++) begin
      r = {1'b0, r[31:1]} ^ ({32{r[0] ^ dibit[i]}} & CRC_POLY_R);
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_rx_framer_if.sv
// eth_rx_framer_if: RMII receive pins plus the byte stream produced by the framer.
//   crsdv_in, rxd_in         RMII carrier-sense/data-valid and receive dibit
//   axiov_out, axiod_out     output byte valid and data
//   axiol_out                last byte of a frame
//   frame_ok_out/_bad_out    frame status, asserted only together with axiol_out
// Handshake: axiov_out alone qualifies axiod_out/axiol_out/frame_*_out for one
// cycle each; there is no ready, so the consumer must accept every valid beat.
// Modports: master = PHY/consumer side, slave = the framer.
interface eth_rx_framer_if;
  logic       crsdv_in;
  logic [1:0] rxd_in;
  logic       axiov_out;
  logic [7:0] axiod_out;
  logic       axiol_out;
  logic       frame_ok_out;
  logic       frame_bad_out;

  modport master (
    output crsdv_in, rxd_in,
    input  axiov_out, axiod_out, axiol_out, frame_ok_out, frame_bad_out
  );

  modport slave (
    input  crsdv_in, rxd_in,
    output axiov_out, axiod_out, axiol_out, frame_ok_out, frame_bad_out
  );
endinterface

// File: rtl/eth_crc32_2b.sv
// eth_crc32_2b: reflected CRC-32 register advanced two bits per clock.
//   clk_in, rst_in  clock, asynchronous active-high reset (reloads CRC_INIT)
//   clr             reload CRC_INIT (takes priority over en)
//   en              fold dibit into the register
//   dibit           RMII dibit, bit 0 earlier on the wire
//   crc             current register value (not complemented)
module eth_crc32_2b
  import eth_rx_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clr,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_dibit(crc, dibit);
    end
  end

endmodule

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: RMII receive framer with destination filtering.
// Strips preamble/SFD, assembles bytes LSb-first, filters on destination
// address, and streams the frame minus its 4-byte FCS via a 6-byte delay line.
// Ports:
//   clk_in, rst_in   50 MHz RMII clock, asynchronous active-high reset
//   bus              eth_rx_framer_if.slave (RMII in, byte stream out)
//   mac_addr_in      N_MAC unicast addresses, entry k at [48k+47:48k], MSB first on wire
//   promisc_in       accept any destination
//   drop_count_out   saturating count of frame_bad_out pulses
//   dbg_state        current state machine state
// Build option: define ETH_RX_CRC_CHECK_EN to check the FCS (CRC-32 residue).
module eth_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int N_MAC        = 2,
  parameter int PRE_MIN      = 8,
  parameter int MIN_LEN      = 18,
  parameter int MAX_LEN      = 1522,
  parameter int ACCEPT_BCAST = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  eth_rx_framer_if.slave       bus,
  input  logic [48*N_MAC-1:0]  mac_addr_in,
  input  logic                 promisc_in,
  output logic [15:0]          drop_count_out,
  output state_t               dbg_state
);

  localparam logic [7:0]  PRE_MIN_V = 8'(PRE_MIN);
  localparam logic [15:0] MIN_LEN_V = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_V = 16'(MAX_LEN);

  state_t      state;
  logic        armed;        // crsdv_in seen low since reset; blocks a frame cut by reset
  logic [7:0]  pre_cnt;
  logic [1:0]  dib_cnt;
  logic [5:0]  byte_sr;      // first three dibits of the byte being assembled
  logic [39:0] dst;          // first five destination bytes
  logic [15:0] byte_cnt;     // complete bytes since SFD
  logic        trunc;        // frame exceeded MAX_LEN; flush and mark bad at its end
  logic [1:0]  flush_cnt;
  logic        frame_bad_r;
  logic [7:0]  dl [6];       // delay line, dl[0] newest, dl[5] oldest

  logic        axiov_r, axiol_r, ok_r, bad_r;
  logic [7:0]  axiod_r;
  logic [15:0] drop_cnt;

  logic        crsdv;
  logic [1:0]  rxd;
  logic [7:0]  new_byte;
  logic [47:0] dest_next;
  logic        addr_match;
  logic        crc_ok;

  assign crsdv     = bus.crsdv_in;
  assign rxd       = bus.rxd_in;
  assign new_byte  = {rxd, byte_sr};
  assign dest_next = {dst, new_byte};

  assign bus.axiov_out     = axiov_r;
  assign bus.axiod_out     = axiod_r;
  assign bus.axiol_out     = axiol_r;
  assign bus.frame_ok_out  = ok_r;
  assign bus.frame_bad_out = bad_r;
  assign drop_count_out    = drop_cnt;
  assign dbg_state         = state;

  always_comb begin
    addr_match = promisc_in;
    if ((ACCEPT_BCAST != 0) && (dest_next == BCAST_ADDR)) addr_match = 1'b1;
    for (int k = 0; k < N_MAC; k++) begin
      if (mac_addr_in[48*k +: 48] == dest_next) addr_match = 1'b1;
    end
  end

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc;
  logic        crc_clr;
  logic        crc_en;

  // Cleared while hunting for the SFD, so the first header dibit starts from CRC_INIT.
  assign crc_clr = (state == PREAMBLE);
  assign crc_en  = crsdv && ((state == HEADER) || (state == PAYLOAD));

  eth_crc32_2b u_crc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (crc_clr),
    .en     (crc_en),
    .dibit  (rxd),
    .crc    (crc)
  );

  assign crc_ok = (crc == CRC_RESIDUE);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      armed       <= 1'b0;
      pre_cnt     <= '0;
      dib_cnt     <= '0;
      byte_sr     <= '0;
      dst         <= '0;
      byte_cnt    <= '0;
      trunc       <= 1'b0;
      flush_cnt   <= '0;
      frame_bad_r <= 1'b0;
      for (int i = 0; i < 6; i++) dl[i] <= '0;
      axiov_r     <= 1'b0;
      axiod_r     <= '0;
      axiol_r     <= 1'b0;
      ok_r        <= 1'b0;
      bad_r       <= 1'b0;
    end else begin
      axiov_r <= 1'b0;
      axiod_r <= '0;
      axiol_r <= 1'b0;
      ok_r    <= 1'b0;
      bad_r   <= 1'b0;
      if (!crsdv) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (crsdv && armed) begin
            state   <= PREAMBLE;
            pre_cnt <= (rxd == PREAMBLE_DIBIT) ? 8'd1 : 8'd0;
          end
        end

        PREAMBLE: begin
          if (!crsdv) begin
            state <= IDLE;
          end else if (rxd == PREAMBLE_DIBIT) begin
            if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
          end else if ((rxd == 2'b00) && (pre_cnt == 8'd0)) begin
            state <= PREAMBLE;   // idle dibits before the first preamble dibit
          end else if ((rxd == SFD_DIBIT) && (pre_cnt >= PRE_MIN_V)) begin
            state    <= HEADER;
            dib_cnt  <= '0;
            byte_cnt <= '0;
            trunc    <= 1'b0;
          end else begin
            state <= DISCARD;
          end
        end

        HEADER: begin
          if (!crsdv) begin
            // A header cut short yields a bare bad marker, but only if a byte arrived.
            if (byte_cnt != 16'd0) begin
              axiov_r <= 1'b1;
              axiol_r <= 1'b1;
              bad_r   <= 1'b1;
            end
            state <= IDLE;
          end else begin
            dib_cnt <= dib_cnt + 2'd1;
            byte_sr <= {rxd, byte_sr[5:2]};
            if (dib_cnt == 2'd3) begin
              for (int i = 5; i > 0; i--) dl[i] <= dl[i-1];
              dl[0]    <= new_byte;
              dst      <= {dst[31:0], new_byte};
              byte_cnt <= byte_cnt + 16'd1;
              if (byte_cnt == 16'd5) state <= addr_match ? PAYLOAD : DISCARD;
            end
          end
        end

        PAYLOAD: begin
          if (!crsdv) begin
            // Delay line is always full here, so two bytes remain ahead of the FCS.
            state       <= FLUSH;
            flush_cnt   <= 2'd2;
            frame_bad_r <= (dib_cnt != 2'd0) || (byte_cnt < MIN_LEN_V) || !crc_ok;
          end else begin
            dib_cnt <= dib_cnt + 2'd1;
            byte_sr <= {rxd, byte_sr[5:2]};
            if (dib_cnt == 2'd3) begin
              if (byte_cnt >= MAX_LEN_V) begin
                state <= DISCARD;
                trunc <= 1'b1;
              end else begin
                axiov_r <= 1'b1;
                axiod_r <= dl[5];
                for (int i = 5; i > 0; i--) dl[i] <= dl[i-1];
                dl[0]    <= new_byte;
                byte_cnt <= byte_cnt + 16'd1;
              end
            end
          end
        end

        DISCARD: begin
          if (!crsdv) begin
            if (trunc) begin
              state       <= FLUSH;
              flush_cnt   <= 2'd2;
              frame_bad_r <= 1'b1;
              trunc       <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        FLUSH: begin
          axiov_r <= 1'b1;
          axiod_r <= dl[5];
          for (int i = 5; i > 0; i--) dl[i] <= dl[i-1];
          flush_cnt <= flush_cnt - 2'd1;
          if (flush_cnt == 2'd1) begin
            axiol_r <= 1'b1;
            ok_r    <= !frame_bad_r;
            bad_r   <= frame_bad_r;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Counts each frame_bad_out pulse one cycle after it, holding at all-ones.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_cnt <= '0;
    end else if (bad_r && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule
